// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: 1-cycle instruction fetch responder (req valid/ready in, rsp valid/ready out with instr/addr/fault) plus program-load port, flush and completed-fetch counter
module imem_fetch_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_instr,
  output logic [31:0]   rsp_addr,
  output logic [1:0]    rsp_fault,
  input  logic          flush,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [31:0]   fetch_count
);
  typedef enum logic {EMPTY, FULL} state_e;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  state_e state_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] off, instr_d, instr_q, addr_q, count_q;
  logic [1:0] fault_d, fault_q;
  logic accept;
  always_comb begin
    off = req_addr - BASE_ADDR;
    fault_d = |req_addr[1:0] ? 2'b01 : ({1'b0, off} >= SPAN) ? 2'b10 : 2'b00;
    instr_d = (fault_d == 2'b00) ? mem[off[2 +: AW]] : NOP_INSTR;
  end
  assign rsp_valid = state_q == FULL;
  assign req_ready = !reset && (!rsp_valid || rsp_ready || flush);
  assign accept = req_valid && req_ready;
  assign rsp_instr = instr_q;
  assign rsp_addr = addr_q;
  assign rsp_fault = fault_q;
  assign fetch_count = count_q;
  always_ff @(posedge clk)
    if (load_en) mem[load_addr] <= load_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      instr_q <= '0;
      addr_q <= '0;
      fault_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_q + 32'(rsp_valid && rsp_ready && !flush);
      if (accept) begin
        state_q <= FULL;
        instr_q <= instr_d;
        addr_q <= req_addr;
        fault_q <= fault_d;
      end else if (rsp_ready || flush) begin
        state_q <= EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: randomized scoreboard bench for imem_fetch_responder
module tb_imem_fetch_responder;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {logic [31:0] instr; logic [31:0] addr; logic [1:0] fault;} rsp_t;
  logic clk = 0, reset = 1, req_valid = 0, rsp_ready = 0, flush = 0, load_en = 0;
  logic [31:0] req_addr = 0, load_data = 0;
  logic [7:0] load_addr = 0;
  logic req_ready, rsp_valid;
  logic [31:0] rsp_instr, rsp_addr, fetch_count;
  logic [1:0] rsp_fault;
  int n_tests = 0, n_fail = 0;
  rsp_t sb[$];
  logic [31:0] tmem [DEPTH];
  bit full = 0;
  logic [31:0] cnt = 0;
  imem_fetch_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_addr(rsp_addr),
    .rsp_fault(rsp_fault), .flush(flush), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic rsp_t model_fetch(logic [31:0] a);
    int unsigned rel = a - BASE;
    if (a % 4 != 0) return '{NOP, a, 2'd1};
    if (rel / 4 >= DEPTH) return '{NOP, a, 2'd2};
    return '{tmem[rel / 4], a, 2'd0};
  endfunction
  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      sb.delete();
      full = 0;
      cnt = 0;
    end else begin
      acc = req_valid && (!full || rsp_ready || flush);
      if (full && flush) sb.delete();
      if (full && rsp_ready && !flush) cnt++;
      if (acc) begin
        sb.push_back(model_fetch(req_addr));
        full = 1;
      end else if (rsp_ready || flush) full = 0;
    end
    if (load_en) tmem[load_addr] = load_data;
  end
  always @(negedge clk) begin
    chk("rsp_valid", 32'(rsp_valid), 32'(full));
    chk("req_ready", 32'(req_ready), 32'(!reset && (!full || rsp_ready || flush)));
    chk("fetch_count", fetch_count, cnt);
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: response addr %h with nothing expected", rsp_addr);
      end else begin
        chk("rsp_instr", rsp_instr, sb[0].instr);
        chk("rsp_addr", rsp_addr, sb[0].addr);
        chk("rsp_fault", 32'(rsp_fault), 32'(sb[0].fault));
        if (rsp_ready && !flush && !reset) void'(sb.pop_front());
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req(logic v, logic [31:0] a, logic rr);
    req_valid = v;
    req_addr = a;
    rsp_ready = rr;
    step();
  endtask
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(9))
      0: return $urandom_range(255) * 4 + $urandom_range(1, 3);
      1: return $urandom | 32'h0000_0400;
      2: return 32'hFFFF_FFFC;
      3: return 32'h0000_0400;
      default: return $urandom_range(255) * 4;
    endcase
  endfunction
  initial begin
    logic [31:0] prog [4];
    logic [31:0] saved;
    prog = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h0000006F};
    #1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      load_en = 1;
      load_addr = 8'(i < DEPTH ? i : i - DEPTH);
      load_data = i < DEPTH ? $urandom : prog[i - DEPTH];
      step();
    end
    load_en = 0;
    @(negedge clk);
    chk("reset_rsp_instr", rsp_instr, 32'h0);
    chk("reset_rsp_addr", rsp_addr, 32'h0);
    chk("reset_rsp_fault", 32'(rsp_fault), 32'h0);
    chk("reset_fetch_count", fetch_count, 32'h0);
    reset = 0;
    step();
    for (int i = 0; i < 4; i++) req(1, 32'(i * 4), 1);
    req(0, 0, 1);
    req(0, 0, 1);
    chk("b2b_count", fetch_count, 32'd4);
    req(1, 32'h4, 0);
    for (int i = 0; i < 3; i++) req(0, 0, 0);
    @(negedge clk);
    chk("hold_instr", rsp_instr, 32'h00100113);
    chk("hold_ready", 32'(req_ready), 32'h0);
    req(0, 0, 1);
    req(0, 0, 1);
    chk("hold_count", fetch_count, 32'd5);
    req(1, 32'h6, 1);
    req(1, 32'h400, 1);
    req(1, 32'h402, 1);
    req(0, 0, 1);
    req(1, 32'h8, 0);
    req(0, 0, 0);
    saved = fetch_count;
    flush = 1;
    req(1, 32'h0, 0);
    flush = 0;
    @(negedge clk);
    chk("flush_addr", rsp_addr, 32'h0);
    req(0, 0, 1);
    req(0, 0, 1);
    chk("flush_count", fetch_count, saved + 1);
    load_en = 1;
    load_addr = 1;
    load_data = 32'hDEADBEEF;
    req(1, 32'h4, 1);
    load_en = 0;
    @(negedge clk);
    chk("rbw_old", rsp_instr, 32'h00100113);
    req(1, 32'h4, 1);
    @(negedge clk);
    chk("rbw_new", rsp_instr, 32'hDEADBEEF);
    req(1, 32'h0, 0);
    reset = 1;
    req(0, 0, 0);
    @(negedge clk);
    chk("midreset_valid", 32'(rsp_valid), 32'h0);
    chk("midreset_count", fetch_count, 32'h0);
    reset = 0;
    req(1, 32'h0, 1);
    @(negedge clk);
    chk("retained_instr", rsp_instr, 32'h00500093);
    req(0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(199) == 0;
      flush = $urandom_range(19) == 0;
      load_en = $urandom_range(4) == 0;
      load_addr = 8'($urandom);
      load_data = $urandom;
      req($urandom_range(3) != 0, rand_addr(), $urandom_range(2) != 0);
    end
    reset = 0;
    flush = 0;
    load_en = 0;
    for (int i = 0; i < 4; i++) req(0, 0, 1);
    chk("drain_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
